// File: rtl/inst_loader.sv
`timescale 1ns/1ps
// Loads instruction memory from a byte stream: 4-byte LE word count, then LE words, one write per word.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int BASE_ADDR = 0,
    parameter int MEM_BYTES = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [ILEN-1:0] mem_wdata,
    output logic            mem_write_en,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_FIN   = S_CSUM;
`else
    localparam logic [2:0] S_FIN   = S_DONE;
`endif

    localparam logic [31:0]     MAX_WORDS = 32'(MEM_BYTES / 4);
    localparam logic [XLEN-1:0] BASE      = XLEN'(BASE_ADDR);

    logic [2:0]      state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     word_cnt_q, word_cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [ILEN-1:0] wdata_q, wdata_d;
    logic            error_q, error_d;
    logic [7:0]      csum_q, csum_d;
    logic [31:0]     len_nxt;
    logic            hs;

    assign rx_ready     = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef INST_LOADER_CHECKSUM_EN
                          || (state_q == S_CSUM)
`endif
                          ;
    assign hs           = rx_valid && rx_ready;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = error_q;
    assign mem_write_en = (state_q == S_WRITE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign len_nxt      = {rx_data, len_q[31:8]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        csum_d     = csum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN;
                    error_d    = 1'b0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 32'd0;
                    addr_d     = BASE;
                    csum_d     = 8'h00;
                end
            end
            S_LEN: begin
                if (hs) begin
                    len_d      = len_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_nxt == 32'd0) begin
                            state_d = S_FIN;
                        end else if (len_nxt > MAX_WORDS) begin
                            // Oversized loads never touch memory and skip the checksum.
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    wdata_d    = {rx_data, wdata_q[ILEN-1:8]};
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d     = addr_q + XLEN'(4);
                word_cnt_d = word_cnt_q + 32'd1;
                state_d    = (word_cnt_q + 32'd1 == len_q) ? S_FIN : S_DATA;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (hs) begin
                    if (rx_data != csum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            word_cnt_q <= 32'd0;
            addr_q     <= BASE;
            wdata_q    <= '0;
            error_q    <= 1'b0;
            csum_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
// Directed bench for inst_loader: normal load, zero length, oversize length, stalls, mid-session reset.
module tb_inst_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en;
    logic        busy;
    logic        done;
    logic        error;

    inst_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write_en(mem_write_en),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Write log captured at the falling edge; bench tasks read it 1ns later.
    int          wr_total    = 0;
    int          wr_rdy_viol = 0;
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];

    always @(negedge clock) begin
        if (mem_write_en === 1'b1) begin
            if (wr_total < 256) begin
                wr_addr[wr_total] = mem_addr;
                wr_data[wr_total] = mem_wdata;
            end
            wr_total++;
            if (rx_ready !== 1'b0) wr_rdy_viol++;
        end
    end

    logic [7:0] s1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                            8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Offers one byte until accepted; bounded so a stuck rx_ready cannot hang the run.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rx_ready === 1'b1) got = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL send_byte_timeout byte=%h rx_ready=%b expected handshake", b, rx_ready);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        step(); step();
        reset = 1'b0;
        step();
        vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b exp=0", mem_write_en); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b exp=0", error); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=00000000", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got=%h exp=00000000", mem_wdata); end
        // A byte offered while idle must not be taken.
        rx_data = 8'hAA; rx_valid = 1'b1;
        step(); step();
        vectors++; if (rx_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_ignore rx_ready=%b busy=%b exp=0/0", rx_ready, busy); end
        rx_valid = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        base = wr_total;
        do_start();
        vectors++; if (busy !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL basic_start busy=%b rdy=%b done=%b exp=1/1/0", busy, rx_ready, done); end
        for (int k = 0; k < 12; k++) begin
            send_byte(s1[k]);
            if (k == 7) begin
                vectors++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00000013) begin miscompares++; $display("FAIL basic_w0 we=%b addr=%h data=%h exp=1/00000000/00000013", mem_write_en, mem_addr, mem_wdata); end
            end
            if (k == 11) begin
                vectors++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h00100093) begin miscompares++; $display("FAIL basic_w1 we=%b addr=%h data=%h exp=1/00000004/00100093", mem_write_en, mem_addr, mem_wdata); end
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h90);
`else
        step();
`endif
        vectors++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_end done=%b err=%b busy=%b exp=1/0/0", done, error, busy); end
        vectors++; if (wr_total - base != 2) begin miscompares++; $display("FAIL basic_wr_count got=%0d exp=2", wr_total - base); end
        vectors++; if (wr_rdy_viol != 0) begin miscompares++; $display("FAIL basic_rdy_in_write got=%0d exp=0", wr_rdy_viol); end
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_total;
        do_start();
        for (int k = 0; k < 4; k++) send_byte(8'h00);
`ifdef INST_LOADER_CHECKSUM_EN
        vectors++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin miscompares++; $display("FAIL zero_csum_wait busy=%b rdy=%b exp=1/1", busy, rx_ready); end
        send_byte(8'h00);
`endif
        vectors++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin miscompares++; $display("FAIL zero_end done=%b err=%b busy=%b rdy=%b exp=1/0/0/0", done, error, busy, rx_ready); end
        vectors++; if (wr_total != base) begin miscompares++; $display("FAIL zero_wr_count got=%0d exp=0", wr_total - base); end
    endtask

    task automatic test_len_error();
        int base;
        logic [7:0] hdr [4];
        hdr  = '{8'h01, 8'h01, 8'h00, 8'h00};
        base = wr_total;
        do_start();
        for (int k = 0; k < 4; k++) send_byte(hdr[k]);
        vectors++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin miscompares++; $display("FAIL lenerr_end done=%b err=%b busy=%b rdy=%b exp=1/1/0/0", done, error, busy, rx_ready); end
        rx_data = 8'h55; rx_valid = 1'b1;
        step(); step(); step();
        rx_valid = 1'b0;
        vectors++; if (wr_total != base || rx_ready !== 1'b0) begin miscompares++; $display("FAIL lenerr_nowrite writes=%0d rdy=%b exp=0/0", wr_total - base, rx_ready); end
    endtask

    task automatic test_gaps();
        int base;
        base = wr_total;
        do_start();
        vectors++; if (error !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL gaps_clear err=%b done=%b exp=0/0", error, done); end
        for (int k = 0; k < 12; k++) begin
            send_byte(s1[k]);
            if (k == 5) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h90);
`endif
        step(); step();
        vectors++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL gaps_end done=%b err=%b busy=%b exp=1/0/0", done, error, busy); end
        vectors++; if (wr_total - base != 2) begin miscompares++; $display("FAIL gaps_wr_count got=%0d exp=2", wr_total - base); end
        vectors++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h00000013) begin miscompares++; $display("FAIL gaps_w0 addr=%h data=%h exp=00000000/00000013", wr_addr[base], wr_data[base]); end
        vectors++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00100093) begin miscompares++; $display("FAIL gaps_w1 addr=%h data=%h exp=00000004/00100093", wr_addr[base+1], wr_data[base+1]); end
        vectors++; if (wr_rdy_viol != 0) begin miscompares++; $display("FAIL gaps_rdy_in_write got=%0d exp=0", wr_rdy_viol); end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [7:0] part [6];
        part = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        base = wr_total;
        do_start();
        for (int k = 0; k < 6; k++) send_byte(part[k]);
        reset = 1'b1;
        step();
        vectors++; if (rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || mem_write_en !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl rdy=%b busy=%b done=%b err=%b we=%b exp=all 0", rx_ready, busy, done, error, mem_write_en); end
        vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL midrst_regs addr=%h data=%h exp=00000000/00000000", mem_addr, mem_wdata); end
        reset = 1'b0;
        rx_data = 8'h77; rx_valid = 1'b1;
        step(); step(); step();
        rx_valid = 1'b0;
        vectors++; if (wr_total != base || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_nowrite writes=%0d busy=%b exp=0/0", wr_total - base, busy); end
        do_start();
        for (int k = 0; k < 12; k++) send_byte(s1[k]);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h90);
`else
        step();
`endif
        vectors++; if (wr_total - base != 2 || done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("FAIL midrst_reload writes=%0d done=%b err=%b exp=2/1/0", wr_total - base, done, error); end
        vectors++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h00100093) begin miscompares++; $display("FAIL midrst_w1 addr=%h data=%h exp=00000004/00100093", wr_addr[base+1], wr_data[base+1]); end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_csum_bad();
        int base;
        base = wr_total;
        do_start();
        for (int k = 0; k < 12; k++) send_byte(s1[k]);
        send_byte(8'h91);
        vectors++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL csum_bad_end done=%b err=%b busy=%b exp=1/1/0", done, error, busy); end
        vectors++; if (wr_total - base != 2) begin miscompares++; $display("FAIL csum_bad_writes got=%0d exp=2", wr_total - base); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_len_error();
        test_gaps();
        test_reset_mid();
`ifdef INST_LOADER_CHECKSUM_EN
        test_csum_bad();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Program loader that fills instruction memory from an external byte stream. It accepts a valid/ready byte stream and parses a 4-byte word-count header followed by little-endian instruction words. Each assembled word drives the memory write port (address, data, write enable) as a single-cycle write. The block sits between the host/debug byte channel and the instruction memory write side, and holds `busy` high so the core stays stalled during loading.

Parameters:
XLEN, 32, address width of mem_addr
ILEN, 32, instruction/word width; must be 32 (4 bytes per word)
BASE_ADDR, 0, byte address of first loaded word
MEM_BYTES, 1024, instruction memory capacity in bytes; max load = MEM_BYTES/4 words

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin load session (sampled in IDLE/DONE only)
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready
mem_addr  output  XLEN  byte address of write
mem_wdata  output  ILEN  write data
mem_write_en  output  1  one-cycle write strobe
busy  output  1  session in progress (LEN/DATA/WRITE/CSUM)
done  output  1  sticky session complete, cleared by next accepted start
error  output  1  sticky session error, cleared by next accepted start

Behaviour:
- Reset: state=IDLE; rx_ready=0, mem_write_en=0, busy=0, done=0, error=0, mem_addr=BASE_ADDR, mem_wdata=0; partial word and counters discarded. Reset mid-session aborts with no further writes.
- States: IDLE, LEN, DATA, WRITE, CSUM (macro only), DONE.
- IDLE/DONE: rx_ready=0. start=1 -> LEN; clear done/error, byte counter, word counter; mem_addr=BASE_ADDR. Bytes offered here are not consumed.
- start while busy: ignored.
- LEN: rx_ready=1. Four handshakes form count N, little-endian (first byte = bits[7:0]). After the 4th byte, next state:
  - N==0 -> DONE
  - N > MEM_BYTES/4 -> error=1, DONE (no writes)
  - otherwise -> DATA
- DATA: rx_ready=1. Bytes assemble little-endian into mem_wdata (byte k -> bits[8k+7:8k]). The 4th byte handshake -> WRITE.
- WRITE: exactly one cycle. mem_write_en=1, rx_ready=0, mem_addr=current address, mem_wdata=assembled word. Latency: write occurs the cycle after the 4th byte handshake. Next cycle:
  - mem_addr += 4 and word counter +1
  - if words written == N -> DONE (or CSUM with macro), else -> DATA
- mem_addr and mem_wdata hold their values outside WRITE; they are only meaningful while mem_write_en=1.
- DONE: done=1, busy=0.
- rx_valid gaps: the loader waits indefinitely with no timeout. A byte is consumed only on handshake; a byte held during WRITE is consumed after it.
- Address cannot exceed BASE_ADDR+MEM_BYTES-4 because of the length check.
- busy is high in LEN, DATA, WRITE, and CSUM.

Optional Feature:
Macro `INST_LOADER_CHECKSUM_EN`.
- Defined: the loader keeps a running XOR of all data bytes (header excluded). After the last WRITE, the CSUM state asserts rx_ready and accepts one byte. If that byte is not equal to the XOR, error=1. Then -> DONE. N==0 still goes to CSUM, and the expected value is 0x00. The length-error path skips CSUM.
- Undefined: there is no CSUM state; the final WRITE goes to DONE, and error is set only by the length check.

Test Plan:
1. Reset, then start, then stream 02 00 00 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 and 0x00100093 @0x4, each with a one-cycle mem_write_en; then done=1, error=0, busy=0.
2. Start, then stream 00 00 00 00 -> no write, done=1 the cycle after the 4th byte, error=0 (without macro).
3. Start, then stream header 01 01 00 00 (N=257, MEM_BYTES=1024) -> error=1, done=1, zero writes, rx_ready=0 afterwards.
4. Repeat scenario 1 with rx_valid toggling every other cycle, and start pulsed mid-session -> identical writes and addresses. rx_ready=0 during each WRITE cycle, no byte lost, start ignored.
5. Start, then N=1, then 2 data bytes, then reset pulse -> all outputs at reset values, no write. A new start plus a full stream of scenario 1 -> correct writes.
6. With the macro, scenario 1 plus trailing byte 0x90 (0x13^0x93^0x10) -> error=0, done=1. The same stream with trailing byte 0x91 -> error=1, done=1, and both words still written.
